apb_master_bridge: RTL

//  APB requester: turns single-beat commands from a local bus into APB SETUP/ACCESS

---
 rtl/apb_master_bridge.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//   APB requester. Each single-beat local command becomes one APB transfer:
//   a SETUP cycle, then one or more ACCESS cycles. The transfer ends when the
//   slave raises pready_i, or when it is aborted after TIMEOUT wait cycles.
//   Only one transfer is in flight at a time, and every output is a register.
//
// Ports
//   pclk_i, prst_i              clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o   command handshake (accept when both high)
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i                 command direction, address and write data
//   rsp_valid_o                 one-cycle response pulse
//   rsp_rdata_o, rsp_timeout_o  response payload, held until next response
//   busy_o                      a transfer is in progress
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o           APB request signals
//   prdata_i, pready_i          APB completion signals, sampled in ACCESS only
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_timeout_o,
    output logic              busy_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i
);

    // The abort fires while the counter holds TIMEOUT-1, so it never needs to
    // represent TIMEOUT itself. With TIMEOUT=0 it only saturates.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              busy_q, busy_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
        end
    end

    // Next-state logic computes the value every output takes in the next
    // state, so the outputs themselves come straight from flops.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        busy_d        = busy_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d     = SETUP;
                    wait_cnt_d  = '0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    psel_d      = 1'b1;
                    pwrite_d    = cmd_write_i;
                    paddr_d     = cmd_addr_i;
                    pwdata_d    = cmd_wdata_i;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_i || (TIMEOUT != 0 && wait_cnt_q == CNT_LAST)) begin
                    state_d       = IDLE;
                    cmd_ready_d   = 1'b1;
                    busy_d        = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = !pready_i;
                    // Writes and aborted transfers report zero data.
                    rsp_rdata_d   = (pready_i && !pwrite_q) ? prdata_i : '0;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign busy_o        = busy_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;

endmodule
